out_buf_tx: RTL and testbench
=============================

# out_buf_tx

Output-buffer drainer: the consumer end of the 256-bit response bus (`out`, `out_bytecount`, `out_rdy`, `out_buf_busy`) driven by command handlers. It captures one response on the rising edge of `out_rdy` and holds `out_buf_busy` high while doing so. It then serialises the response LSB-byte-first into the UART transmitter's byte interface, one byte per `tx_start`/`tx_busy` handshake.

## Interface
- `MAX_BYTES`, 16: maximum payload bytes per response. Fixed by the 4-bit count; not overridable beyond 16.
- `clk` in 1: system clock; all logic on the rising edge.
- `rst` in 1: reset; one clock; reset is synchronous and active-high.
- `out` in 256: response payload. Byte *i* = `out[8i+7:8i]`.
- `out_bytecount` in 4: payload length minus one (0 → 1 byte, 15 → 16 bytes).
- `out_rdy` in 1: producer request, level. A new response is a 0→1 transition.
- `out_buf_busy` out 1: buffer occupied; producers must not raise `out_rdy` while high.
- `tx_d` out 8: byte to UART.
- `tx_start` out 1: one-cycle strobe; `tx_d` valid in the same cycle.
- `tx_busy` in 1: UART busy. Rises no later than 1 cycle after `tx_start`.
- `tx_done` out 1: one-cycle pulse after the last byte of a response is accepted and drained.

## Operation
- **Reset values:** `out_buf_busy`=0, `tx_start`=0, `tx_d`=8'h00, `tx_done`=0, state=IDLE, index=0. The `out_rdy` history register resets to 1, so a level held high through reset is not treated as a new request.
- **Rise detect:** `rise = out_rdy & ~rdy_q`. `rdy_q` tracks `out_rdy` every cycle in all states.
- **IDLE:** on `rise`, latch `out` → shadow, latch `out_bytecount` → last, index=0, `out_buf_busy`=1, go to ISSUE.
- **ISSUE:** if `tx_busy`=0, drive `tx_start`=1 with `tx_d`=shadow byte[index], go to GAP. Otherwise hold.
- **GAP:** one fixed cycle, giving the UART time to raise `tx_busy`. Go to DRAIN.
- **DRAIN:** wait for `tx_busy`=0.
  - If index==last (or the checksum byte was just sent): go to FINISH.
  - Otherwise index+1, go to ISSUE.
- **FINISH:** `tx_done`=1 for one cycle, `out_buf_busy`=0, go to IDLE.
- Index is 4 bits and never wraps. last=15 sends bytes 0..15 and stops.
- A `rise` while not in IDLE is dropped. It is not queued, and `rdy_q` still updates, so there is no deferred resend. This is a producer protocol violation.
- `out`/`out_bytecount` changes after capture have no effect on the response in flight.
- Reset mid-response aborts immediately. No further `tx_start` is issued. A byte already handed to the UART completes there.

## Timing
- Rise sampled at edge *k* → `out_buf_busy`=1 after *k*.
- First `tx_start` after edge *k*+1, if `tx_busy`=0.
- Per-byte overhead beyond UART time: ISSUE 1 + GAP 1 + DRAIN ≥1 cycles.
- `tx_start` is never high on two consecutive cycles.
- `tx_start` is never asserted while `tx_busy`=1.
- `tx_done` and the `out_buf_busy` fall coincide, in the cycle after the final DRAIN exit.
- Earliest next capture: a rise sampled in the cycle after FINISH.

## Configuration
- `OUT_BUF_TX_CHECKSUM_EN` defined:
  - After the last payload byte, send one extra byte: the XOR of all payload bytes sent.
  - It uses the same ISSUE/GAP/DRAIN handshake.
  - `tx_done` fires after the checksum drains.
  - The accumulator clears on capture.
- Undefined: no accumulator logic; exactly bytecount+1 bytes are sent.

## Structure
- Package `out_buf_pkg`:
  - state enum (IDLE, ISSUE, GAP, DRAIN, FINISH; plus CKSUM when enabled);
  - `OUT_BUF_W`=256;
  - `OUT_CNT_W`=4.
- Single module. Byte selection is an indexed part-select of the shadow register; no sub-module is needed.

## Test plan
- **Basic response:** `out`=16'hfefe, bytecount=1, `out_rdy` rises; UART model holds busy for 10 cycles per byte → `tx_d` sequence FE, FE; two `tx_start` pulses; `tx_done` once; `out_buf_busy` low afterwards.
- **Full 16-byte response:** `out[127:0]`=128'h0f0e…0100, bytecount=15 → bytes 00..0F in order; index does not wrap; no 17th strobe.
- **Held level:** `out_rdy` held high for 500 cycles after one response → exactly one transmission. Then drop, re-raise → second transmission.
- **Back-pressure:** `tx_busy` forced high for 20 cycles at capture → `tx_start` withheld until `tx_busy`=0, then asserted within 1 cycle.
- **Reset mid-response:** bytecount=7, assert `rst` after the 3rd byte with `out_rdy` still high → all outputs at reset values next cycle, no further strobes, no resend after reset release.
- **With `OUT_BUF_TX_CHECKSUM_EN`:** `out`=24'h3c_a5_01, bytecount=2 → bytes 01, A5, 3C, then 98; `tx_done` after the 4th byte.

Source files
------------

// File: rtl/out_buf_pkg.sv
// Shared types and sizing for the output-buffer drainer.
// Optional feature: define OUT_BUF_TX_CHECKSUM_EN to append an XOR checksum byte.
package out_buf_pkg;

   localparam int unsigned OUT_BUF_W = 256;  // response bus width
   localparam int unsigned OUT_CNT_W = 4;    // byte-count field width
   localparam int unsigned MAX_BYTES = 16;   // payload bytes addressable by the 4-bit count

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_ISSUE  = 3'd1,
      ST_GAP    = 3'd2,
      ST_DRAIN  = 3'd3,
`ifdef OUT_BUF_TX_CHECKSUM_EN
      ST_FINISH = 3'd4,
      ST_CKSUM  = 3'd5
`else
      ST_FINISH = 3'd4
`endif
   } state_t;

endpackage

// File: rtl/out_buf_tx.sv
// out_buf_tx: captures one 256-bit response on the rising edge of out_rdy and
// serialises it LSB byte first into a UART byte interface (tx_start/tx_busy).
// Optional feature: OUT_BUF_TX_CHECKSUM_EN appends the XOR of all payload bytes.
module out_buf_tx
   import out_buf_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic [OUT_BUF_W-1:0] out,
   input  logic [OUT_CNT_W-1:0] out_bytecount,
   input  logic                 out_rdy,
   output logic                 out_buf_busy,
   output logic [7:0]           tx_d,
   output logic                 tx_start,
   input  logic                 tx_busy,
   output logic                 tx_done
);

   state_t                 state;
   logic [OUT_BUF_W-1:0]   shadow;
   logic [OUT_CNT_W-1:0]   last;
   logic [OUT_CNT_W-1:0]   index;
   logic                   rdy_q;
   logic                   rise;
   logic [7:0]             cur_byte;
`ifdef OUT_BUF_TX_CHECKSUM_EN
   logic [7:0]             cksum;
   logic                   cksum_sent;
`endif

   // New request detection and current payload byte selection.
   always_comb begin
      rise     = out_rdy & ~rdy_q;
      cur_byte = shadow[{1'b0, index, 3'b000} +: 8];
   end

   // Capture / issue / gap / drain sequencer with registered UART strobes.
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= ST_IDLE;
         shadow       <= '0;
         last         <= '0;
         index        <= '0;
         rdy_q        <= 1'b1;
         out_buf_busy <= 1'b0;
         tx_start     <= 1'b0;
         tx_d         <= '0;
         tx_done      <= 1'b0;
`ifdef OUT_BUF_TX_CHECKSUM_EN
         cksum        <= '0;
         cksum_sent   <= 1'b0;
`endif
      end else begin
         rdy_q    <= out_rdy;
         tx_start <= 1'b0;
         tx_done  <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (rise) begin
                  shadow       <= out;
                  last         <= out_bytecount;
                  index        <= '0;
                  out_buf_busy <= 1'b1;
`ifdef OUT_BUF_TX_CHECKSUM_EN
                  cksum        <= '0;
                  cksum_sent   <= 1'b0;
`endif
                  state        <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               if (!tx_busy) begin
                  tx_start <= 1'b1;
                  tx_d     <= cur_byte;
`ifdef OUT_BUF_TX_CHECKSUM_EN
                  cksum    <= cksum ^ cur_byte;
`endif
                  state    <= ST_GAP;
               end
            end
            // Fixed cycle so the UART has time to raise tx_busy.
            ST_GAP: state <= ST_DRAIN;
            ST_DRAIN: begin
               if (!tx_busy) begin
`ifdef OUT_BUF_TX_CHECKSUM_EN
                  if (cksum_sent) begin
                     tx_done      <= 1'b1;
                     out_buf_busy <= 1'b0;
                     state        <= ST_FINISH;
                  end else if (index == last) begin
                     state <= ST_CKSUM;
                  end else begin
                     index <= index + 1'b1;
                     state <= ST_ISSUE;
                  end
`else
                  if (index == last) begin
                     tx_done      <= 1'b1;
                     out_buf_busy <= 1'b0;
                     state        <= ST_FINISH;
                  end else begin
                     index <= index + 1'b1;
                     state <= ST_ISSUE;
                  end
`endif
               end
            end
`ifdef OUT_BUF_TX_CHECKSUM_EN
            ST_CKSUM: begin
               if (!tx_busy) begin
                  tx_start   <= 1'b1;
                  tx_d       <= cksum;
                  cksum_sent <= 1'b1;
                  state      <= ST_GAP;
               end
            end
`endif
            // tx_done is high and out_buf_busy low for exactly this state.
            ST_FINISH: state <= ST_IDLE;
            default:   state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_out_buf_tx.sv
// Directed testbench for out_buf_tx with a simple UART busy model.
// Honours OUT_BUF_TX_CHECKSUM_EN when defined for the build.
module tb_out_buf_tx;
   import out_buf_pkg::*;

   logic                 clk = 1'b0;
   logic                 rst;
   logic [OUT_BUF_W-1:0] out;
   logic [OUT_CNT_W-1:0] out_bytecount;
   logic                 out_rdy;
   logic                 out_buf_busy;
   logic [7:0]           tx_d;
   logic                 tx_start;
   logic                 tx_busy;
   logic                 tx_done;

   int unsigned checks = 0;
   int unsigned passes = 0;

   // UART model: busy for 10 cycles from the edge that samples tx_start.
   int unsigned uart_cnt = 0;
   logic        force_busy = 1'b0;

   // Monitor state
   logic [7:0]  log_q[$];
   int unsigned done_cnt   = 0;
   logic        viol       = 1'b0;
   logic        prev_start = 1'b0;

   always #5 clk = ~clk;

   out_buf_tx dut (
      .clk          (clk),
      .rst          (rst),
      .out          (out),
      .out_bytecount(out_bytecount),
      .out_rdy      (out_rdy),
      .out_buf_busy (out_buf_busy),
      .tx_d         (tx_d),
      .tx_start     (tx_start),
      .tx_busy      (tx_busy),
      .tx_done      (tx_done)
   );

   // UART busy counter.
   always @(posedge clk) begin
      if (tx_start === 1'b1) uart_cnt <= 10;
      else if (uart_cnt != 0) uart_cnt <= uart_cnt - 1;
   end

   assign tx_busy = force_busy | (uart_cnt != 0);

   // Byte log and protocol watch, sampled mid-cycle.
   always @(negedge clk) begin
      if (tx_start === 1'b1) log_q.push_back(tx_d);
      if (tx_done === 1'b1) done_cnt++;
      if (prev_start === 1'b1 && tx_start === 1'b1) viol = 1'b1;
      if (tx_start === 1'b1 && tx_busy === 1'b1) viol = 1'b1;
      if (tx_done === 1'b1 && out_buf_busy !== 1'b0) viol = 1'b1;
      prev_start = tx_start;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic tick(input int unsigned n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_done(input int unsigned budget, input string tag);
      int unsigned start;
      int unsigned k;
      start = done_cnt;
      k = 0;
      while (done_cnt == start && k < budget) begin
         @(negedge clk);
         #1;
         k++;
      end
      check(tag, done_cnt - start, 1);
   endtask

   initial begin
      int unsigned base;
      int unsigned dbase;
      int unsigned k;

      // Reset with out_rdy held high
      rst = 1'b1;
      out_rdy = 1'b1;
      out = '0;
      out_bytecount = '0;
      tick(3);
      check("rst busy", out_buf_busy, 0);
      check("rst tx_start", tx_start, 0);
      check("rst tx_d", tx_d, 8'h00);
      check("rst tx_done", tx_done, 0);
      rst = 1'b0;
      tick(20);
      check("held through reset no tx", log_q.size(), 0);
      check("held through reset idle", out_buf_busy, 0);
      out_rdy = 1'b0;
      tick(2);

      // Basic two-byte response, with first-strobe timing
      base = log_q.size();
      dbase = done_cnt;
      out = 256'hfefe;
      out_bytecount = 4'd1;
      out_rdy = 1'b1;
      tick(1);
      check("basic busy after capture", out_buf_busy, 1);
      check("basic no start yet", tx_start, 0);
      tick(1);
      check("basic first start", tx_start, 1);
      check("basic first byte", tx_d, 8'hfe);
      out = '1;
      out_bytecount = 4'd15;
      wait_done(300, "basic done");
`ifdef OUT_BUF_TX_CHECKSUM_EN
      check("basic count", log_q.size() - base, 3);
      check("basic cksum", log_q[base+2], 8'h00);
`else
      check("basic count", log_q.size() - base, 2);
`endif
      check("basic byte1", log_q[base+1], 8'hfe);
      check("basic busy low", out_buf_busy, 0);

      // Level held high: no retransmission
      base = log_q.size();
      tick(500);
      check("held no resend", log_q.size() - base, 0);
      check("held single done", done_cnt - dbase, 1);
      out_rdy = 1'b0;
      tick(1);
      out = 256'h5a3c;
      out_bytecount = 4'd1;
      out_rdy = 1'b1;
      wait_done(300, "rerise done");
      check("rerise byte0", log_q[base], 8'h3c);
      check("rerise byte1", log_q[base+1], 8'h5a);
`ifdef OUT_BUF_TX_CHECKSUM_EN
      check("rerise cksum", log_q[base+2], 8'h66);
      check("rerise count", log_q.size() - base, 3);
`else
      check("rerise count", log_q.size() - base, 2);
`endif

      // Full 16-byte response
      out_rdy = 1'b0;
      tick(1);
      base = log_q.size();
      out = {128'h0, 128'h0f0e0d0c0b0a09080706050403020100};
      out_bytecount = 4'd15;
      out_rdy = 1'b1;
      wait_done(1000, "full done");
      for (int i = 0; i < 16; i++) check($sformatf("full byte%0d", i), log_q[base+i], i);
`ifdef OUT_BUF_TX_CHECKSUM_EN
      check("full cksum", log_q[base+16], 8'h00);
      tick(100);
      check("full count", log_q.size() - base, 17);
`else
      tick(100);
      check("full count", log_q.size() - base, 16);
`endif

      // Back-pressure at capture
      out_rdy = 1'b0;
      tick(1);
      base = log_q.size();
      force_busy = 1'b1;
      out = 256'h77;
      out_bytecount = 4'd0;
      out_rdy = 1'b1;
      tick(20);
      check("bp withheld", log_q.size() - base, 0);
      check("bp busy", out_buf_busy, 1);
      force_busy = 1'b0;
      tick(1);
      check("bp start", tx_start, 1);
      check("bp byte", tx_d, 8'h77);
      wait_done(300, "bp done");
`ifdef OUT_BUF_TX_CHECKSUM_EN
      check("bp count", log_q.size() - base, 2);
`else
      check("bp count", log_q.size() - base, 1);
`endif

      // Reset after the third byte of an 8-byte response
      out_rdy = 1'b0;
      tick(1);
      base = log_q.size();
      dbase = done_cnt;
      out = 256'h8877665544332211;
      out_bytecount = 4'd7;
      out_rdy = 1'b1;
      k = 0;
      while (log_q.size() - base < 3 && k < 500) begin
         @(negedge clk);
         #1;
         k++;
      end
      check("mid reached 3 bytes", log_q.size() - base, 3);
      rst = 1'b1;
      tick(1);
      check("mid rst busy", out_buf_busy, 0);
      check("mid rst start", tx_start, 0);
      check("mid rst tx_d", tx_d, 8'h00);
      check("mid rst done", tx_done, 0);
      rst = 1'b0;
      tick(300);
      check("mid no more bytes", log_q.size() - base, 3);
      check("mid no done", done_cnt - dbase, 0);
      check("mid byte2", log_q[base+2], 8'h33);

`ifdef OUT_BUF_TX_CHECKSUM_EN
      // Checksum over three bytes
      out_rdy = 1'b0;
      tick(1);
      base = log_q.size();
      out = 256'h3ca501;
      out_bytecount = 4'd2;
      out_rdy = 1'b1;
      wait_done(400, "ck done");
      check("ck count", log_q.size() - base, 4);
      check("ck b0", log_q[base], 8'h01);
      check("ck b1", log_q[base+1], 8'ha5);
      check("ck b2", log_q[base+2], 8'h3c);
      check("ck b3", log_q[base+3], 8'h98);
`endif

      check("protocol", viol, 0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
